// File: rtl/stream_unpacker_pkg.sv
// Shared stream definitions for the word FIFO and the byte unpacker.
// The FIFO stores {last, data} words; the unpacker walks them out one byte at a time.
package stream_unpacker_pkg;

    localparam int WORD_W   = 32;
    localparam int FIFO_W   = 33;
    localparam int LAST_BIT = 32;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } stream_word_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/stream_unpacker_byte_sel.sv
// Combinational byte mux: picks one byte of the held word for the current output position.
module stream_unpacker_byte_sel
    import stream_unpacker_pkg::*;
#(
    parameter int BYTES     = 4,
    parameter int MSB_FIRST = 0,
    parameter int IDX_W     = 2
) (
    input  logic [8*BYTES-1:0] data,
    input  logic [IDX_W-1:0]   idx,
    output logic [7:0]         byte_out
);

    logic [IDX_W-1:0] sel;

    // With MSB_FIRST the position counts down from the top byte instead of up from byte 0.
    always_comb begin
        sel = idx;
        if (MSB_FIRST != 0) begin
            sel = IDX_W'(BYTES - 1) - idx;
        end
    end

    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            if (sel == IDX_W'(i)) begin
                byte_out = data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/stream_unpacker.sv
// Serialises {last, data} words into a byte stream with zero bubbles between words,
// and counts packets whose final byte has been handed downstream.
module stream_unpacker
    import stream_unpacker_pkg::*;
#(
    parameter int BYTES     = 4,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    input  logic [8*BYTES:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   pkt_count,
    output logic               busy
);

    localparam int DATA_W = 8 * BYTES;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    unpack_state_t     state_q, state_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_last_q, hold_last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;

    logic       full;
    logic       last_byte;
    logic       in_fire;
    logic       out_fire;
    logic [7:0] sel_byte;

    assign full      = (state_q == ST_SHIFT);
    assign last_byte = (idx_q == LAST_IDX);
    assign out_fire  = full & out_ready;

    // Ready looks through to out_ready so the next word loads as the last byte leaves.
    assign in_ready  = ~full | (out_fire & last_byte);
    assign in_fire   = in_valid & in_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            idx_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            idx_q       <= idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        idx_d       = idx_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    hold_data_d = in_data[DATA_W-1:0];
                    hold_last_d = in_data[DATA_W];
                    idx_d       = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (out_fire) begin
                    if (!last_byte) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (in_fire) begin
                        hold_data_d = in_data[DATA_W-1:0];
                        hold_last_d = in_data[DATA_W];
                        idx_d       = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end
        endcase

        // Counter wraps naturally at 2^CNT_W.
        if (out_fire && out_last) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end
    end

    stream_unpacker_byte_sel #(
        .BYTES     (BYTES),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_byte_sel (
        .data     (hold_data_q),
        .idx      (idx_q),
        .byte_out (sel_byte)
    );

    assign out_valid = full;
    assign busy      = full;
    assign out_data  = full ? sel_byte : 8'h00;
    assign out_last  = full & hold_last_q & last_byte;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_stream_unpacker.sv
// Drives two unpacker instances (LSB-first with 4-bit counter, MSB-first with 16-bit counter)
// from shared inputs and compares both against a word/byte-position reference model.
module tb_stream_unpacker;

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic [32:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [7:0]  out_data_a;
    logic [3:0]  pkt_count_a;
    logic        in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [7:0]  out_data_b;
    logic [15:0] pkt_count_b;

    int tests;
    int errors;

    // Reference model: the word being emitted and how many of its bytes have gone out.
    bit          m_have;
    logic [31:0] m_word;
    bit          m_last;
    int          m_k;
    int          m_cnt;

    stream_unpacker #(.BYTES(4), .MSB_FIRST(0), .CNT_W(4)) dut_a (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a),
        .out_last  (out_last_a),
        .out_ready (out_ready),
        .pkt_count (pkt_count_a),
        .busy      (busy_a)
    );

    stream_unpacker #(.BYTES(4), .MSB_FIRST(1), .CNT_W(16)) dut_b (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .out_last  (out_last_b),
        .out_ready (out_ready),
        .pkt_count (pkt_count_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelClear();
        m_have = 0;
        m_word = '0;
        m_last = 0;
        m_k    = 0;
        m_cnt  = 0;
    endtask

    // One clock cycle: drive, check every output against the model, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [32:0] id, input logic ordy,
                                 output logic accepted);
        logic [7:0] exp_a, exp_b;
        logic       exp_last, exp_ready, ofire, ifire;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        exp_a     = m_have ? m_word[8*m_k +: 8] : 8'h00;
        exp_b     = m_have ? m_word[8*(3-m_k) +: 8] : 8'h00;
        exp_last  = m_have && m_last && (m_k == 3);
        exp_ready = !m_have || ((m_k == 3) && ordy);
        checkOutput("a_out_valid", 32'(out_valid_a), 32'(m_have));
        checkOutput("a_busy",      32'(busy_a),      32'(m_have));
        checkOutput("a_out_data",  32'(out_data_a),  32'(exp_a));
        checkOutput("a_out_last",  32'(out_last_a),  32'(exp_last));
        checkOutput("a_in_ready",  32'(in_ready_a),  32'(exp_ready));
        checkOutput("a_pkt_count", 32'(pkt_count_a), 32'(m_cnt % 16));
        checkOutput("b_out_valid", 32'(out_valid_b), 32'(m_have));
        checkOutput("b_out_data",  32'(out_data_b),  32'(exp_b));
        checkOutput("b_out_last",  32'(out_last_b),  32'(exp_last));
        checkOutput("b_in_ready",  32'(in_ready_b),  32'(exp_ready));
        checkOutput("b_pkt_count", 32'(pkt_count_b), 32'(m_cnt % 65536));
        ofire    = m_have && ordy;
        ifire    = iv && exp_ready;
        accepted = ifire;
        @(posedge clk);
        if (ofire) begin
            if (m_k == 3) begin
                if (m_last) m_cnt++;
                m_have = 0;
                m_k    = 0;
            end else begin
                m_k++;
            end
        end
        if (ifire) begin
            m_have = 1;
            m_word = id[31:0];
            m_last = id[32];
            m_k    = 0;
        end
    endtask

    task automatic doReset();
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_out_data",  32'(out_data_a),  32'd0);
        checkOutput("rst_out_last",  32'(out_last_a),  32'd0);
        checkOutput("rst_in_ready",  32'(in_ready_a),  32'd1);
        checkOutput("rst_pkt_a",     32'(pkt_count_a), 32'd0);
        checkOutput("rst_pkt_b",     32'(pkt_count_b), 32'd0);
        checkOutput("rst_b_valid",   32'(out_valid_b), 32'd0);
        modelClear();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 33'h0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        int   n;
        tests     = 0;
        errors    = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        modelClear();
        nrst = 1'b0;
        #1;
        checkOutput("init_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("init_in_ready",  32'(in_ready_a),  32'd1);
        checkOutput("init_pkt",       32'(pkt_count_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Single last-flagged word.
        applyStimulus(1'b1, 33'h1_DDCCBBAA, 1'b1, acc);
        checkOutput("single_accept", 32'(acc), 32'd1);
        drain();
        #1;
        checkOutput("single_pkt", 32'(pkt_count_b), 32'd1);

        // Two words offered back to back.
        applyStimulus(1'b1, 33'h0_04030201, 1'b1, acc);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            applyStimulus(1'b1, 33'h1_08070605, 1'b1, acc);
            n++;
        end
        checkOutput("b2b_second_accepted", 32'(acc), 32'd1);
        checkOutput("b2b_accept_cycle", 32'(n), 32'd4);
        drain();
        #1;
        checkOutput("b2b_pkt", 32'(pkt_count_b), 32'd2);

        // Backpressure on the second byte while a junk word is offered.
        applyStimulus(1'b1, 33'h1_DDCCBBAA, 1'b1, acc);
        applyStimulus(1'b0, 33'h0, 1'b1, acc);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 33'h0_12345678, 1'b0, acc);
        drain();
        #1;
        checkOutput("bp_pkt", 32'(pkt_count_b), 32'd3);

        // Reset after byte BB has left, then a fresh single word.
        applyStimulus(1'b1, 33'h1_DDCCBBAA, 1'b1, acc);
        applyStimulus(1'b0, 33'h0, 1'b1, acc);
        applyStimulus(1'b0, 33'h0, 1'b1, acc);
        doReset();
        applyStimulus(1'b1, 33'h1_00000055, 1'b1, acc);
        drain();
        #1;
        checkOutput("post_rst_pkt", 32'(pkt_count_b), 32'd1);

        // Sixteen single-word packets wrap the 4-bit counter.
        doReset();
        n = 0;
        for (int i = 0; i < 100 && n < 16; i++) begin
            applyStimulus(1'b1, {1'b1, $urandom()}, 1'b1, acc);
            if (acc) n++;
        end
        drain();
        #1;
        checkOutput("wrap_pkt_a", 32'(pkt_count_a), 32'd0);
        checkOutput("wrap_pkt_b", 32'(pkt_count_b), 32'd16);

        // Randomised traffic with random backpressure and packet lengths.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 7),
                          {1'($urandom_range(0, 2) == 0), $urandom()},
                          1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
